// File: rtl/alu_seq19.sv
// Sequential ALU producing the data_in_ALU operand for the accumulator.
// Single-cycle ops complete at the accepting edge; MUL/DIV/MOD iterate
// one step per edge through RUN, then commit in FIN.
module alu_seq19 #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam int unsigned CW = $clog2(ITER + 1);

  localparam logic [3:0] OpPassB = 4'd0;
  localparam logic [3:0] OpAdd   = 4'd1;
  localparam logic [3:0] OpSub   = 4'd2;
  localparam logic [3:0] OpInc   = 4'd3;
  localparam logic [3:0] OpDec   = 4'd4;
  localparam logic [3:0] OpShl   = 4'd5;
  localparam logic [3:0] OpShr   = 4'd6;
  localparam logic [3:0] OpMul   = 4'd7;
  localparam logic [3:0] OpDiv   = 4'd8;
  localparam logic [3:0] OpMod   = 4'd9;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, carry_q, ovf_q, dz_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  // hi/lo form the product for MUL, remainder/quotient for DIV/MOD
  logic [WIDTH-1:0] hi_q, lo_q;
  // Multiplicand for MUL, divisor for DIV/MOD
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_dz, is_multi;
  logic [WIDTH:0]   ext;

  // Single-cycle result/flags and multi-cycle detection from live inputs
  always_comb begin
    sc_res   = a;
    sc_carry = 1'b0;
    sc_dz    = 1'b0;
    ext      = '0;
    is_multi = 1'b0;
    case (op)
      OpPassB: sc_res = b;
      OpAdd: begin
        ext      = {1'b0, a} + {1'b0, b};
        sc_res   = ext[WIDTH-1:0];
        sc_carry = ext[WIDTH];
      end
      OpSub: begin
        sc_res   = a - b;
        sc_carry = (a < b);
      end
      OpInc: begin
        ext      = {1'b0, a} + (WIDTH + 1)'(1);
        sc_res   = ext[WIDTH-1:0];
        sc_carry = ext[WIDTH];
      end
      OpDec: begin
        sc_res   = a - WIDTH'(1);
        sc_carry = (a == '0);
      end
      OpShl: begin
        sc_res   = {a[WIDTH-2:0], 1'b0};
        sc_carry = a[WIDTH-1];
      end
      OpShr: begin
        sc_res   = {1'b0, a[WIDTH-1:1]};
        sc_carry = a[0];
      end
      OpMul: is_multi = 1'b1;
      OpDiv, OpMod: begin
        if (b == '0) begin
          sc_res = '1;
          sc_dz  = 1'b1;
        end else begin
          is_multi = 1'b1;
        end
      end
      default: sc_res = a;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  // One shift-add or restoring-divide step on the hi/lo accumulators
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, opnd_q});
    if (op_q == OpMul) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      // Remainder is below the divisor, so the low WIDTH bits suffice
      it_hi = div_ge ? (div_r[WIDTH-1:0] - opnd_q) : div_r[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Control FSM and registered outputs, all updated on the falling edge
  always_ff @(negedge clk) begin
    if (clear) begin
      state_q  <= StIdle;
      result_q <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (is_multi) begin
              op_q    <= op;
              cnt_q   <= CW'(ITER);
              hi_q    <= '0;
              state_q <= StRun;
              if (op == OpMul) begin
                opnd_q <= a;
                lo_q   <= b;
              end else begin
                opnd_q <= b;
                lo_q   <= a;
              end
            end else begin
              result_q <= sc_res;
              carry_q  <= sc_carry;
              ovf_q    <= 1'b0;
              dz_q     <= sc_dz;
              done_q   <= 1'b1;
            end
          end
        end
        StRun: begin
          hi_q  <= it_hi;
          lo_q  <= it_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= StFin;
        end
        StFin: begin
          result_q <= (op_q == OpMod) ? hi_q : lo_q;
          carry_q  <= 1'b0;
          ovf_q    <= (op_q == OpMul) && (hi_q != '0);
          dz_q     <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_alu_seq19.sv
// Directed bench for alu_seq19: a vector table plus hand-written multi-cycle sequences.
module tb_alu_seq19;

  logic        clk = 1'b0;
  logic        clear, start;
  logic [3:0]  op;
  logic [18:0] a, b;
  logic [18:0] result;
  logic        busy, done, carry, ovf, dz;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq19 dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .result(result),
    .busy  (busy),
    .done  (done),
    .carry (carry),
    .ovf   (ovf),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [18:0] a;
    logic [18:0] b;
    logic [18:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          edges;
    int          busy_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE; DUT samples on negedge, outputs are read on posedge.
  task automatic run_op(input logic [3:0] o, input logic [18:0] av, input logic [18:0] bv,
                        output int edges, output int busy_cyc);
    @(posedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    #1 start = 1'b0;
    edges = -1;
    busy_cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        edges = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vt[17];
  int   e, bc, cnt;

  initial begin
    vt[0]  = '{4'd1, 19'h7FFFF, 19'h00001, 19'h00000, 1, 0, 0, 0, 0};
    vt[1]  = '{4'd2, 19'h00005, 19'h00009, 19'h7FFFC, 1, 0, 0, 0, 0};
    vt[2]  = '{4'd3, 19'h7FFFF, 19'h00000, 19'h00000, 1, 0, 0, 0, 0};
    vt[3]  = '{4'd4, 19'h00000, 19'h00000, 19'h7FFFF, 1, 0, 0, 0, 0};
    vt[4]  = '{4'd4, 19'h00005, 19'h00000, 19'h00004, 0, 0, 0, 0, 0};
    vt[5]  = '{4'd5, 19'h40001, 19'h00000, 19'h00002, 1, 0, 0, 0, 0};
    vt[6]  = '{4'd6, 19'h00003, 19'h00000, 19'h00001, 1, 0, 0, 0, 0};
    vt[7]  = '{4'd0, 19'h00011, 19'h12345, 19'h12345, 0, 0, 0, 0, 0};
    vt[8]  = '{4'd12, 19'h2BCDE, 19'h11111, 19'h2BCDE, 0, 0, 0, 0, 0};
    vt[9]  = '{4'd7, 19'h003E8, 19'h0012C, 19'h493E0, 0, 0, 0, 20, 20};
    vt[10] = '{4'd7, 19'h00400, 19'h00400, 19'h00000, 0, 1, 0, 20, 20};
    vt[11] = '{4'd1, 19'h00001, 19'h00002, 19'h00003, 0, 0, 0, 0, 0};
    vt[12] = '{4'd8, 19'h493E0, 19'h00007, 19'h0A769, 0, 0, 0, 20, 20};
    vt[13] = '{4'd9, 19'h493E0, 19'h00007, 19'h00001, 0, 0, 0, 20, 20};
    vt[14] = '{4'd8, 19'h00005, 19'h00000, 19'h7FFFF, 0, 0, 1, 0, 0};
    vt[15] = '{4'd6, 19'h00004, 19'h00000, 19'h00002, 0, 0, 0, 0, 0};
    vt[16] = '{4'd9, 19'h00005, 19'h00000, 19'h7FFFF, 0, 0, 1, 0, 0};

    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1 clear = 1'b0;
    @(posedge clk);
    chk("reset result", 32'(result), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset flags", 32'({carry, ovf, dz}), 32'h0);

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, e, bc);
      chk($sformatf("v%0d result", i), 32'(result), 32'(vt[i].res));
      chk($sformatf("v%0d flags", i), 32'({carry, ovf, dz}),
          32'({vt[i].c, vt[i].v, vt[i].z}));
      chk($sformatf("v%0d latency", i), 32'(e), 32'(vt[i].edges));
      chk($sformatf("v%0d busy cycles", i), 32'(bc), 32'(vt[i].busy_cyc));
      @(posedge clk);
      chk($sformatf("v%0d done width", i), 32'(done), 32'h0);
    end

    // Back-to-back SUB then INC: two consecutive done pulses
    @(posedge clk);
    start = 1'b1; op = 4'd2; a = 19'h00005; b = 19'h00009;
    @(negedge clk);
    @(posedge clk);
    chk("b2b done1", 32'(done), 32'h1);
    chk("b2b sub result", 32'({carry, result}), 32'({1'b1, 19'h7FFFC}));
    op = 4'd3; a = 19'h7FFFF;
    @(negedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    chk("b2b done2", 32'(done), 32'h1);
    chk("b2b inc result", 32'({carry, result}), 32'({1'b1, 19'h00000}));
    @(posedge clk);
    chk("b2b done end", 32'(done), 32'h0);

    // Start during RUN ignored; operand changes not seen by the running MUL
    @(posedge clk);
    start = 1'b1; op = 4'd7; a = 19'h003E8; b = 19'h0012C;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 start = 1'b1; op = 4'd1;
    @(negedge clk);
    #1 a = 19'h00007; b = 19'h00009;
    @(posedge clk);
    chk("ign no done E5", 32'(done), 32'h0);
    @(negedge clk);
    #1 start = 1'b0;
    e = 6;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (done) break;
      @(negedge clk);
      e++;
    end
    chk("ign latency", 32'(e), 32'd20);
    chk("ign mul result", 32'({ovf, result}), 32'({1'b0, 19'h493E0}));
    @(posedge clk);
    chk("ign no requeue", 32'({busy, done}), 32'h0);

    // Clear aborts an in-flight MUL
    run_op(4'd1, 19'h7FFFF, 19'h00002, e, bc);
    chk("pre-clear add", 32'({carry, result}), 32'({1'b1, 19'h00001}));
    @(posedge clk);
    start = 1'b1; op = 4'd7; a = 19'h00400; b = 19'h00400;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    #1 clear = 1'b0;
    @(posedge clk);
    chk("clr busy", 32'(busy), 32'h0);
    chk("clr result", 32'(result), 32'h0);
    chk("clr flags", 32'({carry, ovf, dz}), 32'h0);
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      if (done) cnt++;
      @(posedge clk);
    end
    chk("clr no done", 32'(cnt), 32'h0);
    run_op(4'd1, 19'h00002, 19'h00003, e, bc);
    chk("post-clr add", 32'({carry, result}), 32'({1'b0, 19'h00005}));
    chk("post-clr latency", 32'(e), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq19.md
Name: alu_seq19

Overview:
- Sequential 19-bit ALU. It produces the data_in_ALU operand that feeds the accumulator register and the pass path.
- Operand a comes from AC; operand b comes from the datapath bus (RX/RK/MI).
- Single-cycle arithmetic and logic ops complete in one edge. MUL/DIV/MOD run as iterative shift-add / restoring-divide loops.
- A start/busy/done handshake tells the control unit when to assert LD_ALU_AC.

Parameters:
- WIDTH, 19, datapath width; must match the AC/RX/RK width.
- ITER, WIDTH, iterations for MUL/DIV/MOD.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, matching the register timing.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while idle.
- op  in  4  opcode, latched with start.
- a  in  WIDTH  operand A (AC value).
- b  in  WIDTH  operand B (bus value).
- result  out  WIDTH  registered result; drives AC data_in_ALU.
- busy  out  1  high while a MUL/DIV/MOD iteration is in progress.
- done  out  1  one-cycle completion pulse.
- carry  out  1  ADD carry-out / SUB borrow.
- ovf  out  1  MUL product exceeds WIDTH bits.
- dz  out  1  divide by zero.

Behaviour:
- Reset (clear at negedge):
  - state=IDLE; result=0; done=0; busy=0; carry=0; ovf=0; dz=0; counter=0.
  - clear beats start and aborts any in-flight op; no done pulse is produced.
- Opcodes:
  - 0 PASSB: result=b.
  - 1 ADD: result=a+b; carry = bit WIDTH of the sum.
  - 2 SUB: result=a-b mod 2^WIDTH; carry=1 iff a<b, unsigned.
  - 3 INC: result=a+1; carry on wrap.
  - 4 DEC: result=a-1; carry=1 iff a==0.
  - 5 SHL: result=a<<1; carry=a[WIDTH-1].
  - 6 SHR: result=a>>1, logical; carry=a[0].
  - 7 MUL: unsigned; result=low WIDTH bits; ovf=1 iff the high WIDTH bits are nonzero.
  - 8 DIV: unsigned quotient.
  - 9 MOD: unsigned remainder.
  - 10-15: NOP; result=a; all flags 0.
- FSM states are IDLE, RUN, FIN.
- IDLE + start, single-cycle op or NOP (call this edge E0):
  - At E0: result and flags update; done=1; state stays IDLE.
  - done returns to 0 at E1 unless another op completes at E1.
  - Back-to-back starts each cycle are legal.
- IDLE + start, MUL/DIV/MOD with nonzero divisor:
  - At E0: latch a, b, op; clear the accumulators; counter=ITER; state=RUN; busy=1.
  - busy is decoded from state. result and flags hold their previous values during RUN.
- RUN:
  - One iteration per negedge; counter decrements.
  - The edge at which counter reaches 0 moves state to FIN.
  - FIN: at the next edge (E(ITER+1)), write result and flags, set done=1, state=IDLE, busy=0.
  - Total: done is high in the cycle after edge E(ITER+1). That is ITER+1 edges after acceptance (20 for the defaults).
- DIV/MOD with b==0:
  - Single-cycle at E0; result = all ones (7FFFF); dz=1; done=1; no RUN.
- Flag rules:
  - Every completion rewrites all of carry/ovf/dz; flags that do not apply to the op go to 0.
  - Flags and result hold until the next completion.
- start while busy (RUN/FIN): ignored, not queued. The a/b/op changes are not seen by the running op.
- start during FIN: ignored.
- start in the same cycle as done (state IDLE): accepted.
- MUL iterations: a 2·WIDTH product register, shift-add on the LSB of the multiplier.
- DIV iterations: restoring division. Quotient and remainder are WIDTH-bit; the op selects which one goes to result.

Test Plan:
- clear, then ADD a=7FFFF b=00001 -> after E0: result=00000, carry=1, done high exactly one cycle, busy never high.
- SUB a=5 b=9 -> result=7FFFC, carry=1. Then INC a=7FFFF on the next cycle, back-to-back -> result=0, carry=1, two consecutive done pulses.
- MUL a=1000 b=300 -> busy high 20 cycles, result=300000 (493E0), ovf=0. MUL a=1024 b=1024 -> result=0, ovf=1.
- DIV a=300000 b=7 -> result=42857, done at edge E20. MOD with the same operands -> result=1. DIV a=5 b=0 -> result=7FFFF, dz=1, done at E0.
- MUL started; a second start with op=ADD asserted at E5; operand changes at E6 -> second start ignored, final MUL result unaffected.
- MUL started; clear asserted at E10 -> state IDLE, busy=0, result=0, flags=0, no done pulse. A new ADD start right after is accepted normally.
